// File: rtl/magnus_test.sv
// Demo tile: enable-gated 8-bit counter behind a programmable prescaler,
// shown as two hex digits time-multiplexed on one 7-segment output.
module magnus_test #(
   parameter int PRESCALE = 1
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic clk;
   logic srst;
   logic en;
   logic unused_pins;

   assign clk         = io_in[0];
   assign srst        = io_in[1];
   assign en          = io_in[2];
   assign unused_pins = ^io_in[7:3];

   logic [7:0]    count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          sel_q, sel_d;

   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      sel_d   = ~sel_q;
      if (en) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = count_q + 8'd1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         count_q <= 8'd0;
         presc_q <= '0;
         sel_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         sel_q   <= sel_d;
      end
   end

   function automatic logic [6:0] seg(input logic [3:0] digit);
      logic [6:0] s;
      case (digit)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Display is straight off the registers so digit select and segments change together.
   always_comb begin
      io_out[7]   = sel_q;
      io_out[6:0] = seg(sel_q ? count_q[7:4] : count_q[3:0]);
   end

endmodule

// File: tb/tb_magnus_test.sv
// Directed bench: two instances (PRESCALE=1 and PRESCALE=4) driven in lockstep
// from a table of {rst, en, unused pins, edge count, expected outputs}.
module tb_magnus_test;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [4:0] hi  = 5'd0;
   logic [7:0] io_in;
   logic [7:0] out1, out4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   assign io_in = {hi, en, rst, clk};

   magnus_test #(.PRESCALE(1)) dut1 (.io_in(io_in), .io_out(out1));
   magnus_test #(.PRESCALE(4)) dut4 (.io_in(io_in), .io_out(out4));

   typedef struct {
      logic       rst;
      logic       en;
      logic [4:0] hi;
      int         reps;
      logic [7:0] exp1;
      logic [7:0] exp4;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic e, input logic [4:0] h,
                               input int n, input logic [7:0] x1, input logic [7:0] x4);
      vec_t v;
      v.rst = r; v.en = e; v.hi = h; v.reps = n; v.exp1 = x1; v.exp4 = x4;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [7:0] p4_seq[8] = '{8'hBF, 8'h3F, 8'hBF, 8'h06, 8'hBF, 8'h06, 8'hBF, 8'h5B};

   initial begin
      // reset, reset priority over en
      vecs.push_back(mk(1, 0, 5'h00, 1,   8'h3F, 8'h3F));
      vecs.push_back(mk(1, 1, 5'h1F, 2,   8'h3F, 8'h3F));
      // en=0: digit select alternates, count holds; unused pins wiggled
      vecs.push_back(mk(0, 0, 5'h1F, 1,   8'hBF, 8'hBF));
      vecs.push_back(mk(0, 0, 5'h0A, 1,   8'h3F, 8'h3F));
      vecs.push_back(mk(0, 0, 5'h15, 1,   8'hBF, 8'hBF));
      vecs.push_back(mk(0, 0, 5'h00, 1,   8'h3F, 8'h3F));
      vecs.push_back(mk(0, 0, 5'h00, 1,   8'hBF, 8'hBF));
      vecs.push_back(mk(0, 0, 5'h00, 1,   8'h3F, 8'h3F));
      // counting
      vecs.push_back(mk(0, 1, 5'h00, 1,   8'hBF, 8'hBF));
      vecs.push_back(mk(0, 1, 5'h15, 1,   8'h5B, 8'h3F));
      vecs.push_back(mk(0, 1, 5'h00, 1,   8'hBF, 8'hBF));
      vecs.push_back(mk(0, 1, 5'h00, 1,   8'h66, 8'h06));
      vecs.push_back(mk(0, 1, 5'h00, 14,  8'h5B, 8'h66));
      vecs.push_back(mk(0, 0, 5'h00, 1,   8'h86, 8'hBF));
      vecs.push_back(mk(0, 0, 5'h00, 1,   8'h5B, 8'h66));
      // wrap
      vecs.push_back(mk(1, 1, 5'h00, 1,   8'h3F, 8'h3F));
      vecs.push_back(mk(0, 1, 5'h00, 255, 8'hF1, 8'hCF));
      vecs.push_back(mk(0, 1, 5'h00, 1,   8'h3F, 8'h3F));
      vecs.push_back(mk(0, 0, 5'h00, 1,   8'hBF, 8'hE6));
      // prescale pause/resume
      vecs.push_back(mk(1, 0, 5'h00, 1,   8'h3F, 8'h3F));
      vecs.push_back(mk(0, 1, 5'h00, 10,  8'h77, 8'h5B));
      vecs.push_back(mk(0, 0, 5'h00, 5,   8'hBF, 8'hBF));
      vecs.push_back(mk(0, 1, 5'h00, 1,   8'h7C, 8'h5B));
      vecs.push_back(mk(0, 1, 5'h00, 1,   8'hBF, 8'hBF));
      vecs.push_back(mk(0, 0, 5'h00, 1,   8'h39, 8'h4F));
      // mid-count reset
      vecs.push_back(mk(1, 1, 5'h00, 1,   8'h3F, 8'h3F));
      vecs.push_back(mk(0, 1, 5'h00, 90,  8'h77, 8'h7D));
      vecs.push_back(mk(1, 1, 5'h00, 1,   8'h3F, 8'h3F));
      vecs.push_back(mk(0, 1, 5'h00, 1,   8'hBF, 8'hBF));
      vecs.push_back(mk(0, 1, 5'h00, 1,   8'h5B, 8'h3F));

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst;
         en  = vecs[i].en;
         hi  = vecs[i].hi;
         repeat (vecs[i].reps) @(posedge clk);
         #1;
         check($sformatf("vec%0d_p1", i), out1, vecs[i].exp1);
         check($sformatf("vec%0d_p4", i), out4, vecs[i].exp4);
         $display("vec %0d: rst=%0b en=%0b edges=%0d out1=%h out4=%h",
                  i, vecs[i].rst, vecs[i].en, vecs[i].reps, out1, out4);
      end

      // Edge-by-edge prescale boundary on the PRESCALE=4 instance.
      @(negedge clk);
      rst = 1'b1; en = 1'b0;
      @(posedge clk); #1;
      check("seq_reset_p4", out4, 8'h3F);
      @(negedge clk);
      rst = 1'b0; en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         check($sformatf("seq_edge%0d_p4", k + 1), out4, p4_seq[k]);
         $display("seq edge %0d: out4=%h", k + 1, out4);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/magnus_test.md
Name: magnus_test

Overview:
- Demo tile behind the standard 8-in/8-out pad wrapper.
- An enable-gated 8-bit up-counter, advanced through a programmable prescaler, is shown as two hex digits on a single 7-segment output.
- The two nibbles are time-multiplexed on alternate clock cycles.
- io_out[7] flags which digit is currently driven.

Parameters:
- PRESCALE, 1, number of enabled clock edges per counter increment. Legal range is 1..256; 1 means increment on every enabled edge.

Ports:
- io_in[0]  input  1  clk; the single clock, rising-edge active.
- io_in[1]  input  1  rst; synchronous, active-high reset.
- io_in[2]  input  1  en; count enable, active-high.
- io_in[7:3]  input  5  unused; ignored; tied 0 at top level.
- io_out[6:0]  output  7  segment drive, active-high. bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- io_out[7]  output  1  digit select. 0 = low nibble shown, 1 = high nibble shown.
- The block's ports are io_in[7:0] and io_out[7:0]. Clock is io_in[0] (clk). Reset is io_in[1] (rst), synchronous and active-high.

Behaviour:
- State registers:
  - count[7:0]
  - presc, width ceil(log2(PRESCALE)) with a minimum of 1 bit
  - sel (1 bit)
- Reset, on a rising clk edge with rst=1:
  - count=0, presc=0, sel=0.
  - Reset has priority over en.
  - Resulting output is io_out = 0x3F.
- Each rising edge with rst=0:
  - sel <= ~sel, unconditionally (independent of en).
  - If en=1 and presc == PRESCALE-1: presc <= 0 and count <= count+1.
  - If en=1 otherwise: presc <= presc+1.
  - If en=0: count and presc hold.
- Counter wrap: 0xFF+1 -> 0x00. No carry output.
- Output logic:
  - Purely combinational from registered state; no extra pipeline stage.
  - io_out[7] = sel.
  - io_out[6:0] = seg(sel ? count[7:4] : count[3:0]).
  - Outputs therefore update in the same cycle as the state edge.
- seg() table, hex digit -> 7-bit value:
  - 0->3F, 1->06, 2->5B, 3->4F, 4->66, 5->6D, 6->7D, 7->07
  - 8->7F, 9->6F, A->77, b->7C, C->39, d->5E, E->79, F->71
- en toggling mid-prescale: presc keeps its partial value while en=0 and resumes from it when en returns to 1.
- Reset mid-operation: all three registers clear on the next edge regardless of en or prescale phase.
- No X on io_out after the first reset edge. io_in[7:3] has no effect on any state.

Test Plan:
- Hold rst=1 for 3 edges (en=0 or 1) -> io_out = 0x3F after each edge.
- Release rst, en=0, run 6 edges -> io_out alternates 0xBF, 0x3F, 0xBF, 0x3F, 0xBF, 0x3F; count stays 0.
- PRESCALE=1, en=1 for 18 edges after reset -> count=0x12.
  - Edges where sel=0 show 0x5B (digit 2).
  - Edges where sel=1 show 0x86 (0x80 | seg 1).
- PRESCALE=1, en=1 for 256 edges -> count wraps to 0x00; outputs return to 0x3F / 0xBF.
- PRESCALE=4, en=1 for 10 edges -> count=2, presc=2.
  - Drop en for 5 edges -> count stays 2.
  - Re-enable for 2 edges -> count=3.
- Mid-count reset: count=0x5A, assert rst for 1 edge with en=1 -> io_out = 0x3F, count=0, sel=0.
  - Next edge with en=1 (PRESCALE=1) -> io_out = 0xBF (high nibble 0), count=1.
